// File: rtl/au_seq_ctrl.sv
// Multi-cycle execution controller for the 16-bit arithmetic unit.
// Owns the GPR file and the SGPR; single-cycle mov/add/sub/mul and a 16-step restoring divider.
module au_seq_ctrl #(
    parameter int NREG = 32,
    parameter int DW   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    input  logic [31:0]   instr,
    output logic          instr_ready,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          err_illegal,
    output logic          err_dz,
    output logic [DW-1:0] sgpr,
    input  logic [4:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);

    localparam int CW = $clog2(DW);

    localparam logic [4:0] OP_MOVSGPR = 5'd0;
    localparam logic [4:0] OP_MOV     = 5'd1;
    localparam logic [4:0] OP_ADD     = 5'd2;
    localparam logic [4:0] OP_SUB     = 5'd3;
    localparam logic [4:0] OP_MUL     = 5'd4;
    localparam logic [4:0] OP_DIV     = 5'd5;

    typedef enum logic [1:0] {IDLE, EXEC, DIV} state_t;

    state_t state, state_next;

    logic [DW-1:0] gpr [NREG];

    logic [4:0]    op;
    logic [4:0]    rd;
    logic          imm;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] rem;
    logic [DW-1:0] quo;
    logic [CW-1:0] cnt;

    logic            accept;
    logic            wr_en;
    logic [DW-1:0]   wr_val;
    logic            sgpr_en;
    logic            fin;
    logic            ill;
    logic            dz;
    logic            div_start;
    logic            div_step;
    logic [DW:0]     rem_sh;
    logic            rem_ge;
    logic [DW-1:0]   rem_next;
    logic [DW-1:0]   quo_next;
    logic [2*DW-1:0] product;

    assign instr_ready = (state == IDLE);
    assign busy        = ~instr_ready;
    assign accept      = instr_ready && instr_valid;
    assign dbg_data    = gpr[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_val     = '0;
        sgpr_en    = 1'b0;
        fin        = 1'b0;
        ill        = 1'b0;
        dz         = 1'b0;
        div_start  = 1'b0;
        div_step   = 1'b0;

        // One restoring-division step; rem_sh needs an extra bit since it can reach 2*B-1.
        rem_sh   = {rem, quo[DW-1]};
        rem_ge   = (rem_sh >= {1'b0, b});
        rem_next = rem_ge ? (rem_sh[DW-1:0] - b) : rem_sh[DW-1:0];
        quo_next = {quo[DW-2:0], rem_ge};
        product  = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};

        case (state)
            IDLE: begin
                if (instr_valid) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = IDLE;
                fin        = 1'b1;
                wr_en      = 1'b1;
                case (op)
                    OP_MOVSGPR: wr_val = sgpr;
                    OP_MOV:     wr_val = imm ? b : a;
                    OP_ADD:     wr_val = a + b;
                    OP_SUB:     wr_val = a - b;
                    OP_MUL: begin
                        wr_val  = product[DW-1:0];
                        sgpr_en = 1'b1;
                    end
                    OP_DIV: begin
                        if (b == '0) begin
                            wr_val = '1;
                            dz     = 1'b1;
                        end else begin
                            state_next = DIV;
                            fin        = 1'b0;
                            wr_en      = 1'b0;
                            div_start  = 1'b1;
                        end
                    end
                    default: begin
                        wr_en = 1'b0;
                        ill   = 1'b1;
                    end
                endcase
            end
            DIV: begin
                div_step = 1'b1;
                if (cnt == CW'(DW - 1)) begin
                    state_next = IDLE;
                    fin        = 1'b1;
                    wr_en      = 1'b1;
                    wr_val     = quo_next;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands are captured at acceptance so a later write to rdst cannot disturb them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op          <= '0;
            rd          <= '0;
            imm         <= 1'b0;
            a           <= '0;
            b           <= '0;
            rem         <= '0;
            quo         <= '0;
            cnt         <= '0;
            sgpr        <= '0;
            result      <= '0;
            done        <= 1'b0;
            err_illegal <= 1'b0;
            err_dz      <= 1'b0;
        end else begin
            done        <= fin;
            err_illegal <= ill;
            err_dz      <= dz;
            if (accept) begin
                op  <= instr[31:27];
                rd  <= instr[26:22];
                imm <= instr[16];
                a   <= gpr[instr[21:17]];
                b   <= instr[16] ? instr[15:0] : gpr[instr[15:11]];
            end
            if (fin) begin
                result <= wr_val;
            end
            if (sgpr_en) begin
                sgpr <= product[2*DW-1:DW];
            end
            if (div_start) begin
                rem <= '0;
                quo <= a;
                cnt <= '0;
            end else if (div_step) begin
                rem <= rem_next;
                quo <= quo_next;
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                gpr[i] <= '0;
            end
        end else if (wr_en) begin
            gpr[rd] <= wr_val;
        end
    end

endmodule

// File: tb/tb_au_seq_ctrl.sv
// Directed, table-driven bench for au_seq_ctrl with hand-written sequences
// for the busy-window and mid-divide reset cases.
module tb_au_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        err_illegal;
    logic        err_dz;
    logic [15:0] sgpr;
    logic [4:0]  dbg_addr;
    logic [15:0] dbg_data;

    int total = 0;
    int bad   = 0;

    au_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .err_illegal (err_illegal),
        .err_dz      (err_dz),
        .sgpr        (sgpr),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [4:0]  chk_reg;
        logic [15:0] exp_result;
        logic [15:0] exp_sgpr;
        logic        exp_ill;
        logic        exp_dz;
        int          exp_lat;
    } vec_t;

    function automatic logic [31:0] enc_reg(input logic [4:0] op, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, 1'b0, rs2, 11'b0};
    endfunction

    function automatic logic [31:0] enc_imm(input logic [4:0] op, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [15:0] isrc);
        return {op, rd, rs1, 1'b1, isrc};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one instruction through its accepting edge, then drops valid.
    task automatic applyStimulus(input logic [31:0] ins);
        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic waitDone(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) break;
        end
        if (!done) begin
            lat = -1;
        end
    endtask

    task automatic runVector(input vec_t v, input int idx);
        int lat;
        applyStimulus(v.ins);
        waitDone(lat);
        checkOutput($sformatf("v%0d latency", idx), lat, v.exp_lat);
        checkOutput($sformatf("v%0d result", idx), result, v.exp_result);
        checkOutput($sformatf("v%0d err_illegal", idx), err_illegal, v.exp_ill);
        checkOutput($sformatf("v%0d err_dz", idx), err_dz, v.exp_dz);
        checkOutput($sformatf("v%0d sgpr", idx), sgpr, v.exp_sgpr);
        dbg_addr = v.chk_reg;
        #1;
        checkOutput($sformatf("v%0d gpr[%0d]", idx, v.chk_reg), dbg_data, v.exp_result);
    endtask

    vec_t vecs[$];

    initial begin
        int lat;
        int busy_bad;
        int late_done;

        vecs.push_back('{enc_imm(5'd1, 5'd4,  5'd0,  16'd55),   5'd4,  16'd55,   16'h0000, 1'b0, 1'b0, 1});
        vecs.push_back('{enc_reg(5'd2, 5'd2,  5'd4,  5'd4),     5'd2,  16'd110,  16'h0000, 1'b0, 1'b0, 1});
        vecs.push_back('{enc_imm(5'd1, 5'd5,  5'd0,  16'hFFFF), 5'd5,  16'hFFFF, 16'h0000, 1'b0, 1'b0, 1});
        vecs.push_back('{enc_imm(5'd4, 5'd6,  5'd5,  16'hFFFF), 5'd6,  16'h0001, 16'hFFFE, 1'b0, 1'b0, 1});
        vecs.push_back('{enc_reg(5'd0, 5'd7,  5'd0,  5'd0),     5'd7,  16'hFFFE, 16'hFFFE, 1'b0, 1'b0, 1});
        vecs.push_back('{enc_imm(5'd1, 5'd8,  5'd0,  16'd100),  5'd8,  16'd100,  16'hFFFE, 1'b0, 1'b0, 1});
        vecs.push_back('{enc_imm(5'd1, 5'd9,  5'd0,  16'd7),    5'd9,  16'd7,    16'hFFFE, 1'b0, 1'b0, 1});
        vecs.push_back('{enc_imm(5'd1, 5'd11, 5'd0,  16'd5),    5'd11, 16'd5,    16'hFFFE, 1'b0, 1'b0, 1});
        vecs.push_back('{enc_imm(5'd5, 5'd12, 5'd11, 16'd2),    5'd12, 16'd2,    16'hFFFE, 1'b0, 1'b0, 17});
        vecs.push_back('{enc_imm(5'd5, 5'd13, 5'd5,  16'd1),    5'd13, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0, 17});
        vecs.push_back('{enc_imm(5'd5, 5'd14, 5'd11, 16'd0),    5'd14, 16'hFFFF, 16'hFFFE, 1'b0, 1'b1, 1});
        vecs.push_back('{enc_imm(5'd9, 5'd15, 5'd4,  16'd3),    5'd15, 16'h0000, 16'hFFFE, 1'b1, 1'b0, 1});
        vecs.push_back('{enc_imm(5'd1, 5'd16, 5'd0,  16'd3),    5'd16, 16'd3,    16'hFFFE, 1'b0, 1'b0, 1});
        vecs.push_back('{enc_imm(5'd1, 5'd17, 5'd0,  16'd5),    5'd17, 16'd5,    16'hFFFE, 1'b0, 1'b0, 1});
        vecs.push_back('{enc_reg(5'd3, 5'd18, 5'd16, 5'd17),    5'd18, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0, 1});
        vecs.push_back('{enc_imm(5'd1, 5'd3,  5'd0,  16'd5),    5'd3,  16'd5,    16'hFFFE, 1'b0, 1'b0, 1});
        vecs.push_back('{enc_imm(5'd2, 5'd3,  5'd3,  16'd1),    5'd3,  16'd6,    16'hFFFE, 1'b0, 1'b0, 1});

        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        dbg_addr    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 32; r++) begin
            dbg_addr = 5'(r);
            #1;
            checkOutput($sformatf("reset gpr[%0d]", r), dbg_data, 16'h0000);
        end
        checkOutput("reset sgpr", sgpr, 16'h0000);
        checkOutput("reset instr_ready", instr_ready, 1'b1);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset done", done, 1'b0);
        checkOutput("reset result", result, 16'h0000);

        for (int i = 0; i < vecs.size(); i++) begin
            runVector(vecs[i], i);
        end

        dbg_addr = 5'd15;
        #1;
        checkOutput("illegal left gpr[15]", dbg_data, 16'h0000);

        // 100 / 7 with junk offered while busy; none of it may be taken.
        applyStimulus(enc_reg(5'd5, 5'd10, 5'd8, 5'd9));
        busy_bad = 0;
        lat      = 0;
        while (lat < 40) begin
            if (lat >= 1 && lat <= 10) begin
                instr       = enc_imm(5'd1, 5'd20, 5'd0, 16'h1234);
                instr_valid = 1'b1;
            end else begin
                instr_valid = 1'b0;
            end
            @(posedge clk);
            lat++;
            #1;
            if (done) break;
            if (!busy || instr_ready) busy_bad++;
        end
        instr_valid = 1'b0;
        checkOutput("div100/7 latency", done ? lat : -1, 17);
        checkOutput("div100/7 result", result, 16'd14);
        checkOutput("div100/7 busy window", busy_bad, 0);
        checkOutput("div100/7 ready with done", instr_ready, 1'b1);
        dbg_addr = 5'd10;
        #1;
        checkOutput("div100/7 gpr[10]", dbg_data, 16'd14);
        dbg_addr = 5'd20;
        #1;
        checkOutput("ignored while busy gpr[20]", dbg_data, 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("done single pulse", done, 1'b0);

        // Reset asserted during the eighth divide iteration.
        applyStimulus(enc_imm(5'd5, 5'd19, 5'd8, 16'd3));
        repeat (9) @(posedge clk);
        #1;
        checkOutput("mid-div busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort instr_ready", instr_ready, 1'b1);
        checkOutput("abort done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        late_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done) late_done++;
        end
        checkOutput("abort no done", late_done, 0);
        checkOutput("abort ready", instr_ready, 1'b1);
        dbg_addr = 5'd19;
        #1;
        checkOutput("abort gpr[19]", dbg_data, 16'h0000);
        checkOutput("abort sgpr", sgpr, 16'h0000);

        runVector('{enc_imm(5'd1, 5'd19, 5'd0, 16'd7), 5'd19, 16'd7, 16'h0000, 1'b0, 1'b0, 1}, 99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/au_seq_ctrl.md
# au_seq_ctrl

Multi-cycle execution controller for the 16-bit arithmetic unit. It accepts one 32-bit instruction at a time over a valid/ready handshake, latches its operands from the 32×16 general-purpose register file it owns, and executes the operation. Mov, add, sub and mul complete in one cycle. Div runs as a 16-iteration restoring divider. The controller then writes back and signals completion; it sits between the instruction issue stage and the register file.

## Interface
- `NREG`, default 32: number of GPRs; fixed by the 5-bit register fields.
- `DW`, default 16: data width; the divider iterates `DW` times.
- `clk` input, 1 bit: rising-edge clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `instr_valid` input, 1 bit: instruction offered.
- `instr` input, 32 bits: fields are opcode[31:27], rdst[26:22], rsrc1[21:17], imm_mode[16], rsrc2[15:11], isrc[15:0].
- `instr_ready` output, 1 bit: controller can accept; high only in IDLE.
- `busy` output, 1 bit: inverse of `instr_ready`.
- `done` output, 1 bit: one-cycle completion pulse.
- `result` output, `DW` bits: value written to rdst by the last completed instruction; held until the next `done`.
- `err_illegal` output, 1 bit: qualified by `done`; the completed opcode was not in 0–5.
- `err_dz` output, 1 bit: qualified by `done`; the completed div had divisor 0.
- `sgpr` output, `DW` bits: special register holding the mul high half.
- `dbg_addr` input, 5 bits: debug read address.
- `dbg_data` output, `DW` bits: combinational `GPR[dbg_addr]`.

## Operation
- Opcodes:
  - 0 movsgpr: rdst ← SGPR.
  - 1 mov: rdst ← imm ? isrc : GPR[rsrc1].
  - 2 add, 3 sub: rdst ← GPR[rsrc1] ± (imm ? isrc : GPR[rsrc2]), mod 2^16.
  - 4 mul: 32-bit unsigned product; low half → rdst, high half → SGPR.
  - 5 div: unsigned quotient → rdst; remainder is discarded.
- Operand B is `isrc` when imm_mode=1, otherwise `GPR[rsrc2]`. The rsrc2 field is ignored for mov and movsgpr.
- Operands are latched at acceptance, so rdst equal to rsrc1 or rsrc2 reads the old value.
- SGPR changes only on mul.
- FSM states IDLE, EXEC, DIV:
  - IDLE: `instr_ready`=1. `instr_valid`&&`instr_ready` at an edge latches opcode, rdst, A and B, then goes to EXEC.
  - EXEC (one cycle):
    - Ops 0–4 and illegal opcodes: write, pulse `done`, return to IDLE.
    - Div with B=0: write 16'hFFFF to rdst, set `err_dz`, pulse `done`, return to IDLE.
    - Div with B≠0: clear remainder, load quotient ← A, count ← 0, go to DIV.
  - DIV: each cycle shifts {rem,quo} left 1. If rem ≥ B, subtract B and set quo[0]. After the 16th iteration (count=15): write quo, pulse `done`, return to IDLE.
- Illegal opcode: no GPR or SGPR write; `result` ← 0; `err_illegal`=1 with `done`.
- `instr` and `instr_valid` are ignored while busy; no queuing.
- Reset:
  - State goes to IDLE and all outputs deassert.
  - All GPRs, SGPR, `result`, `done`, `err_illegal` and `err_dz` go to 0.
  - `instr_ready` goes to 1.
  - Reset during EXEC or DIV aborts the instruction with no writeback.

## Timing
- Accept at edge k. For non-div, illegal, or div by zero: GPR write at edge k+1, and `done` is high during the cycle after k+1.
- Div with nonzero divisor: write and `done` at edge k+17 (1 EXEC + 16 DIV cycles).
- `instr_ready` drops the cycle after acceptance and returns together with `done`. The next instruction can be accepted at edge k+2 (non-div) or k+18 (div).
- Maximum throughput is one instruction per 2 cycles.
- `dbg_data` reflects a write from the cycle after the write edge.
- `err_*` flags are registered with `done` and cleared on the next edge.

## Test plan
- Reset, then `dbg_addr`=0..31 → all 0; `sgpr`=0; `instr_ready`=1; `done`=0.
- mov imm rdst=4, isrc=55 → `done` 1 cycle after accept; GPR[4]=55; `result`=55. Then add reg rdst=2, rsrc1=4, rsrc2=4 → GPR[2]=110.
- Preload 0xFFFF via mov imm, then mul imm rsrc1 holding 0xFFFF, isrc=0xFFFF → rdst=0x0001, `sgpr`=0xFFFE. A following movsgpr → rdst=0xFFFE.
- Div:
  - 100 / 7 (reg) → `done` exactly 17 edges after accept; rdst=14; `busy`=1 throughout; `instr_valid` pulses while busy are ignored.
  - 5 / 2 (imm) → 2.
  - 0xFFFF / 1 → 0xFFFF.
- Divide by zero: div imm isrc=0 → `done` at k+1; rdst=0xFFFF; `err_dz`=1. Opcode 9 → `err_illegal`=1; no register changes; sub 3−5 → 0xFFFE (wrap).
- Assert `rst_n` low at DIV iteration 8 → rdst unchanged (0); no `done`; `instr_ready`=1 after release. Also add rdst=rsrc1=3 with GPR[3]=5, isrc=1 → GPR[3]=6.
